// File: rtl/vga_pkg.sv
// Shared definitions for the framebuffer arbiter: default widths and the
// RAM-slot owner encoding that travels down the read-return pipeline.
package vga_pkg;

    localparam int AW_DEF     = 32;
    localparam int DW_DEF     = 24;
    localparam int STARVE_DEF = 64;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_VGA    = 2'd1,
        OWN_CPU_RD = 2'd2,
        OWN_CPU_WR = 2'd3
    } owner_e;

    // True when the slot belongs to the CPU, read or write.
    function automatic logic is_cpu(input owner_e own);
        return (own == OWN_CPU_RD) || (own == OWN_CPU_WR);
    endfunction

endpackage

// File: rtl/contador_saturado.sv
// Width-parameterised up-counter that sticks at all-ones; async active-low clear.
module contador_saturado #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step on enable unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/arbitro_framebuffer.sv
// Framebuffer RAM arbiter: one slot per pixel clock shared between the display
// fetch and the CPU, with a starvation override that may displace a VGA fetch.
module arbitro_framebuffer
    import vga_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_rdata,
    output logic          vga_valid,
    output logic          vga_miss,
    output logic [15:0]   miss_count,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    // Slot issue registers
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic          mem_we_q,    mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q,   cpu_ack_d;
    logic          vga_miss_q,  vga_miss_d;
    logic [SW-1:0] starve_q,    starve_d;
    // Owner tags for the two cycles of RAM + capture latency
    owner_e        tag1_q,      tag1_d;
    owner_e        tag2_q,      tag2_d;
    // Read-return registers
    logic          vga_valid_q,  vga_valid_d;
    logic [DW-1:0] vga_rdata_q,  vga_rdata_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;

    owner_e owner_s;
    logic   cpu_ok_s;
    logic   force_s;

    // Owner selection; cpu_ack_q doubles as the one-cycle lockout after a CPU slot.
    always_comb begin
        owner_s  = OWN_NONE;
        cpu_ok_s = cpu_req && !cpu_ack_q;
        force_s  = 1'b0;
        if (cpu_ok_s && (starve_q == STARVE_LIM)) begin
            force_s = 1'b1;
            owner_s = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
        end else if (vga_req) begin
            owner_s = OWN_VGA;
        end else if (cpu_ok_s) begin
            owner_s = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
        end else begin
            owner_s = OWN_NONE;
        end
    end

    // Next values for the slot issue, starvation tracking and return pipeline.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        vga_miss_d  = force_s && vga_req;

        case (owner_s)
            OWN_VGA: begin
                mem_addr_d = vga_addr;
            end
            OWN_CPU_RD: begin
                mem_addr_d = cpu_addr;
                cpu_ack_d  = 1'b1;
            end
            OWN_CPU_WR: begin
                mem_addr_d  = cpu_addr;
                mem_we_d    = 1'b1;
                mem_wdata_d = cpu_wdata;
                cpu_ack_d   = 1'b1;
            end
            OWN_NONE: begin
                mem_addr_d = mem_addr_q;
            end
            default: begin
                mem_addr_d = mem_addr_q;
            end
        endcase

        if (is_cpu(owner_s) || !cpu_req) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        tag1_d = owner_s;
        tag2_d = tag1_q;

        vga_valid_d  = (tag2_q == OWN_VGA);
        cpu_rvalid_d = (tag2_q == OWN_CPU_RD);
        if (vga_valid_d) begin
            vga_rdata_d = mem_rdata;
        end else begin
            vga_rdata_d = vga_rdata_q;
        end
        if (cpu_rvalid_d) begin
            cpu_rdata_d = mem_rdata;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
    end

    // State registers; reset drops any in-flight tags so no stale valid escapes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            vga_miss_q   <= 1'b0;
            starve_q     <= '0;
            tag1_q       <= OWN_NONE;
            tag2_q       <= OWN_NONE;
            vga_valid_q  <= 1'b0;
            vga_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            vga_miss_q   <= vga_miss_d;
            starve_q     <= starve_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            vga_valid_q  <= vga_valid_d;
            vga_rdata_q  <= vga_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    contador_saturado #(.W(16)) u_miss_cnt (
        .clk   (clk),
        .clr_n (reset),
        .en    (vga_miss_d),
        .count (miss_count)
    );

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign vga_miss   = vga_miss_q;
    assign vga_valid  = vga_valid_q;
    assign vga_rdata  = vga_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_arbitro_framebuffer.sv
// Directed bench for arbitro_framebuffer: cycle table plus reset and saturation sequences.
module tb_arbitro_framebuffer;

    logic        clk;
    logic        reset;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic [23:0] vga_rdata;
    logic        vga_valid;
    logic        vga_miss;
    logic [15:0] miss_count;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [23:0] cpu_wdata;
    logic        cpu_ack;
    logic [23:0] cpu_rdata;
    logic        cpu_rvalid;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;

    logic        sat_clr_n;
    logic        sat_en;
    logic [2:0]  sat_count;

    int checks = 0;
    int errors = 0;

    arbitro_framebuffer #(.AW(32), .DW(24), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_rdata  (vga_rdata),
        .vga_valid  (vga_valid),
        .vga_miss   (vga_miss),
        .miss_count (miss_count),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Small-width instance to exercise the saturating miss counter at its ceiling.
    contador_saturado #(.W(3)) u_sat (
        .clk   (clk),
        .clr_n (sat_clr_n),
        .en    (sat_en),
        .count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 1-cycle read latency; unwritten words read back as their address.
    logic [23:0] ram_val [256];
    bit          ram_vld [256];
    always @(posedge clk) begin
        if (mem_we) begin
            ram_val[mem_addr[7:0]] <= mem_wdata;
            ram_vld[mem_addr[7:0]] <= 1'b1;
        end
        mem_rdata <= ram_vld[mem_addr[7:0]] ? ram_val[mem_addr[7:0]] : {16'h0000, mem_addr[7:0]};
    end

    typedef struct {
        logic        vreq;
        logic [7:0]  vaddr;
        logic        creq;
        logic        cwe;
        logic [7:0]  caddr;
        logic [23:0] cwd;
        logic        ack;
        logic        vv;
        logic [23:0] vd;
        logic        cv;
        logic [23:0] cd;
        logic        miss;
        logic        mwe;
        logic [7:0]  maddr;
        logic [15:0] mcnt;
    } vec_t;

    localparam int NV = 38;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic vreq, input logic [7:0] vaddr, input logic creq, input logic cwe,
        input logic [7:0] caddr, input logic [23:0] cwd, input logic ack, input logic vv,
        input logic [23:0] vd, input logic cv, input logic [23:0] cd, input logic miss,
        input logic mwe, input logic [7:0] maddr, input logic [15:0] mcnt);
        vec_t v;
        v.vreq = vreq; v.vaddr = vaddr; v.creq = creq; v.cwe = cwe; v.caddr = caddr;
        v.cwd = cwd; v.ack = ack; v.vv = vv; v.vd = vd; v.cv = cv; v.cd = cd;
        v.miss = miss; v.mwe = mwe; v.maddr = maddr; v.mcnt = mcnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        vga_req   = v.vreq;
        vga_addr  = {24'h000000, v.vaddr};
        cpu_req   = v.creq;
        cpu_we    = v.cwe;
        cpu_addr  = {24'h000000, v.caddr};
        cpu_wdata = v.cwd;
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("cpu_ack",    idx, 32'(cpu_ack),    32'(v.ack));
        chk("vga_valid",  idx, 32'(vga_valid),  32'(v.vv));
        chk("vga_rdata",  idx, 32'(vga_rdata),  32'(v.vd));
        chk("cpu_rvalid", idx, 32'(cpu_rvalid), 32'(v.cv));
        chk("cpu_rdata",  idx, 32'(cpu_rdata),  32'(v.cd));
        chk("vga_miss",   idx, 32'(vga_miss),   32'(v.miss));
        chk("mem_we",     idx, 32'(mem_we),     32'(v.mwe));
        chk("mem_addr",   idx, mem_addr,        {24'h000000, v.maddr});
        chk("miss_count", idx, 32'(miss_count), 32'(v.mcnt));
    endtask

    task automatic chk_reset_vals(input int idx);
        vec_t z;
        z = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0,
               1'b0, 1'b0, 8'h00, 16'h0000);
        chk_all(idx, z);
        chk("mem_wdata_rst", idx, 32'(mem_wdata), 32'h0);
    endtask

    initial begin
        vec_t idle;
        idle = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 24'h0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0,
                  1'b0, 1'b0, 8'h00, 16'h0000);

        // Display stream 0..9 then drain
        for (int i = 0; i < 10; i++) begin
            tbl[i] = mk(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 24'h0, 1'b0, (i >= 2),
                        (i >= 2) ? 24'(i - 2) : 24'h0, 1'b0, 24'h0, 1'b0, 1'b0, 8'(i), 16'd0);
        end
        tbl[10] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 1, 24'h8, 0, 24'h0,     0, 0, 8'h09, 16'd0);
        tbl[11] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 1, 24'h9, 0, 24'h0,     0, 0, 8'h09, 16'd0);
        tbl[12] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 0, 24'h9, 0, 24'h0,     0, 0, 8'h09, 16'd0);
        // CPU write, lockout, read back
        tbl[13] = mk(0, 8'h00, 1, 1, 8'h10, 24'hABCDEF, 1, 0, 24'h9, 0, 24'h0,    0, 1, 8'h10, 16'd0);
        tbl[14] = mk(0, 8'h00, 1, 0, 8'h10, 24'h0,     0, 0, 24'h9, 0, 24'h0,     0, 0, 8'h10, 16'd0);
        tbl[15] = mk(0, 8'h00, 1, 0, 8'h10, 24'h0,     1, 0, 24'h9, 0, 24'h0,     0, 0, 8'h10, 16'd0);
        tbl[16] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 0, 24'h9, 0, 24'h0,     0, 0, 8'h10, 16'd0);
        tbl[17] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 0, 24'h9, 1, 24'hABCDEF, 0, 0, 8'h10, 16'd0);
        tbl[18] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 0, 24'h9, 0, 24'hABCDEF, 0, 0, 8'h10, 16'd0);
        // Interleaved VGA / CPU reads
        tbl[19] = mk(1, 8'h20, 0, 0, 8'h00, 24'h0,     0, 0, 24'h9,  0, 24'hABCDEF, 0, 0, 8'h20, 16'd0);
        tbl[20] = mk(0, 8'h00, 1, 0, 8'h41, 24'h0,     1, 0, 24'h9,  0, 24'hABCDEF, 0, 0, 8'h41, 16'd0);
        tbl[21] = mk(1, 8'h22, 0, 0, 8'h00, 24'h0,     0, 1, 24'h20, 0, 24'hABCDEF, 0, 0, 8'h22, 16'd0);
        tbl[22] = mk(0, 8'h00, 1, 0, 8'h43, 24'h0,     1, 0, 24'h20, 1, 24'h41,    0, 0, 8'h43, 16'd0);
        tbl[23] = mk(1, 8'h24, 0, 0, 8'h00, 24'h0,     0, 1, 24'h22, 0, 24'h41,    0, 0, 8'h24, 16'd0);
        tbl[24] = mk(0, 8'h00, 1, 0, 8'h45, 24'h0,     1, 0, 24'h22, 1, 24'h43,    0, 0, 8'h45, 16'd0);
        tbl[25] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 1, 24'h24, 0, 24'h43,    0, 0, 8'h45, 16'd0);
        tbl[26] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 0, 24'h24, 1, 24'h45,    0, 0, 8'h45, 16'd0);
        tbl[27] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 0, 24'h24, 0, 24'h45,    0, 0, 8'h45, 16'd0);
        // Starvation: CPU forced on 5th edge, VGA 0x64 displaced
        tbl[28] = mk(1, 8'h60, 1, 0, 8'h7F, 24'h0,     0, 0, 24'h24, 0, 24'h45,    0, 0, 8'h60, 16'd0);
        tbl[29] = mk(1, 8'h61, 1, 0, 8'h7F, 24'h0,     0, 0, 24'h24, 0, 24'h45,    0, 0, 8'h61, 16'd0);
        tbl[30] = mk(1, 8'h62, 1, 0, 8'h7F, 24'h0,     0, 1, 24'h60, 0, 24'h45,    0, 0, 8'h62, 16'd0);
        tbl[31] = mk(1, 8'h63, 1, 0, 8'h7F, 24'h0,     0, 1, 24'h61, 0, 24'h45,    0, 0, 8'h63, 16'd0);
        tbl[32] = mk(1, 8'h64, 1, 0, 8'h7F, 24'h0,     1, 1, 24'h62, 0, 24'h45,    1, 0, 8'h7F, 16'd1);
        tbl[33] = mk(1, 8'h65, 0, 0, 8'h00, 24'h0,     0, 1, 24'h63, 0, 24'h45,    0, 0, 8'h65, 16'd1);
        tbl[34] = mk(1, 8'h66, 0, 0, 8'h00, 24'h0,     0, 0, 24'h63, 1, 24'h7F,    0, 0, 8'h66, 16'd1);
        tbl[35] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 1, 24'h65, 0, 24'h7F,    0, 0, 8'h66, 16'd1);
        tbl[36] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 1, 24'h66, 0, 24'h7F,    0, 0, 8'h66, 16'd1);
        tbl[37] = mk(0, 8'h00, 0, 0, 8'h00, 24'h0,     0, 0, 24'h66, 0, 24'h7F,    0, 0, 8'h66, 16'd1);

        // Reset phase
        reset     = 1'b0;
        sat_clr_n = 1'b0;
        sat_en    = 1'b0;
        drive(idle);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals(-1);
        chk("sat_clear", -1, 32'(sat_count), 32'h0);

        @(negedge clk);
        reset     = 1'b1;
        sat_clr_n = 1'b1;

        // Table-driven cycles
        for (int r = 0; r < NV; r++) begin
            drive(tbl[r]);
            @(posedge clk);
            #1;
            chk_all(r, tbl[r]);
            @(negedge clk);
        end

        // Reset pulsed one cycle after a VGA grant discards that fetch
        vga_req  = 1'b1;
        vga_addr = 32'h30;
        @(posedge clk);
        #1;
        chk("rst_seq_grant", 100, mem_addr, 32'h30);
        @(negedge clk);
        reset   = 1'b0;
        vga_req = 1'b0;
        #1;
        chk_reset_vals(101);
        @(negedge clk);
        chk_reset_vals(102);
        reset    = 1'b1;
        vga_req  = 1'b1;
        vga_addr = 32'h05;
        @(posedge clk);
        #1;
        chk("rst_first_grant", 103, mem_addr, 32'h05);
        chk("rst_no_stale_v",  103, 32'(vga_valid), 32'h0);
        @(negedge clk);
        vga_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_no_stale_v",  104, 32'(vga_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_new_valid",   105, 32'(vga_valid), 32'h1);
        chk("rst_new_data",    105, 32'(vga_rdata), 32'h05);
        chk("rst_cnt_clear",   105, 32'(miss_count), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_single_v",    106, 32'(vga_valid), 32'h0);

        // Saturating counter stays at its ceiling
        @(negedge clk);
        sat_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk("sat_count", 200 + k, 32'(sat_count), (k < 7) ? 32'(k) : 32'h7);
        end
        @(negedge clk);
        sat_en = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_hold", 211, 32'(sat_count), 32'h7);
        @(negedge clk);
        sat_clr_n = 1'b0;
        #1;
        chk("sat_async_clr", 212, 32'(sat_count), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_framebuffer.md
ARBITRO_FRAMEBUFFER -- requirements
Module: arbitro_framebuffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): AW, 32, address width; DW, 24, pixel data width (8R/8G/8B); STARVE_MAX, 64, CPU wait cycles before forced slot.
REQ-002 Ports SHALL be (name direction width meaning):
 clk  input  1  single clock for all logic (pixel clock domain)
 reset  input  1  asynchronous, active-low reset
 vga_req  input  1  display fetch request, one per pixel cycle
 vga_addr  input  AW  display fetch address
 vga_rdata  output  DW  fetched pixel
 vga_valid  output  1  vga_rdata valid, one-cycle pulse
 vga_miss  output  1  a VGA request was displaced by a forced CPU slot, one-cycle pulse
 miss_count  output  16  saturating count of vga_miss pulses
 cpu_req  input  1  CPU access request, level
 cpu_we  input  1  1 = write, 0 = read
 cpu_addr  input  AW  CPU address
 cpu_wdata  input  DW  CPU write data
 cpu_ack  output  1  CPU slot issued, one-cycle pulse
 cpu_rdata  output  DW  CPU read data
 cpu_rvalid  output  1  cpu_rdata valid, one-cycle pulse
 mem_addr  output  AW  framebuffer RAM address
 mem_we  output  1  framebuffer RAM write enable
 mem_wdata  output  DW  framebuffer RAM write data
 mem_rdata  input  DW  framebuffer RAM read data, 1-cycle synchronous latency

Function
REQ-003 At each rising edge N the block SHALL select one owner for the RAM slot: VGA, CPU_RD, CPU_WR or NONE.
REQ-004 Priority SHALL be: forced CPU (starvation) > vga_req > cpu_req > NONE.
REQ-005 mem_addr, mem_we, mem_wdata and cpu_ack SHALL be registered and valid in the cycle following edge N.
REQ-006 mem_we SHALL be 1 only for owner CPU_WR; mem_wdata SHALL hold the captured cpu_wdata for CPU_WR and hold its previous value otherwise.
REQ-007 For owner NONE, mem_addr SHALL hold its previous value and mem_we SHALL be 0.
REQ-008 Read data SHALL be registered from mem_rdata at edge N+2; vga_valid or cpu_rvalid SHALL be high for exactly the cycle after edge N+2, per the owner tag carried in a 2-stage pipeline.
REQ-009 vga_rdata/cpu_rdata SHALL hold their last value when their valid is low.
REQ-010 A CPU write SHALL produce cpu_ack only; no cpu_rvalid.
REQ-011 Following a cpu_ack, the block SHALL NOT grant the CPU at the next edge (one-cycle lockout); cpu_req still high after the lockout is a new request.
REQ-012 A starvation counter SHALL increment at every edge where cpu_req=1 and the CPU is not granted, and SHALL clear on CPU grant or when cpu_req=0.
REQ-013 When the counter equals STARVE_MAX and cpu_req=1, the CPU SHALL be granted regardless of vga_req; if vga_req=1 at that edge, vga_miss SHALL pulse and miss_count SHALL increment, saturating at 16'hFFFF.
REQ-014 A displaced VGA request SHALL NOT be retried; vga_valid SHALL be absent for that slot.
REQ-015 Back-to-back VGA requests SHALL yield one vga_valid per cycle with no bubbles.
REQ-016 Pipeline tags SHALL be independent per slot, so VGA and CPU reads may interleave cycle by cycle with correct data routing.

Reset
REQ-017 While reset=0: mem_addr=0, mem_we=0, mem_wdata=0, cpu_ack=0, vga_valid=0, cpu_rvalid=0, vga_miss=0, vga_rdata=0, cpu_rdata=0, miss_count=0, starvation counter=0, pipeline tags=NONE, lockout clear.
REQ-018 Reset asserted mid-operation SHALL discard in-flight reads; no valid pulse SHALL appear for requests issued before reset.
REQ-019 The first grant after reset release SHALL occur at the first rising edge with reset=1.

Structure
REQ-020 Shared package vga_pkg SHALL hold AW/DW defaults and the owner enum (OWN_NONE, OWN_VGA, OWN_CPU_RD, OWN_CPU_WR).
REQ-021 miss_count SHALL be implemented in sub-module contador_saturado (width-parameterised, enable, asynchronous active-low clear).

Verification
REQ-022 vga_req=1 continuously, addrs 0..9, RAM model data=addr -> vga_valid each cycle from edge 2 on, vga_rdata 0..9 in order.
REQ-023 Idle VGA, CPU write addr 0x10 data 0xABCDEF, then read 0x10 -> cpu_ack twice, with lockout cycle between; cpu_rvalid with 0xABCDEF.
REQ-024 vga_req and cpu_req both 1, STARVE_MAX=4 -> CPU granted after 4 waited cycles; vga_miss=1 once; miss_count=1; VGA resumes next cycle.
REQ-025 Alternating VGA/CPU reads to distinct addresses -> each valid asserted on the correct port with matching data.
REQ-026 Reset pulsed one cycle after a VGA grant -> no vga_valid; all outputs at reset values.
REQ-027 miss_count preloaded near 16'hFFFF via forced misses -> holds at 16'hFFFF.
